xor_nn_seq: RTL

Time-multiplexed sequencer and weight store for the small fully-connected XOR network (INPUT_SIZE inputs, one ReLU hidden layer of HIDDEN_SIZE neurons, one output). It accepts a serial weight stream into an internal register file. It then evaluates one input vector at a time with a single shared multiply-accumulate, one MAC per clock, and returns a one-cycle result pulse. It sits between the host bus and the network datapath and replaces the fully-unrolled single-cycle evaluation.

---
 rtl/xor_nn_seq_if.sv | 32 +++
 rtl/xor_nn_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/xor_nn_seq_if.sv
// Host-side bus bundle for xor_nn_seq.
//   master : host side, drives weight/input streams and observes results.
//   slave  : sequencer side.
// Signals:
//   weights_en/weights_data -> weight word stream, weights_ready/weights_loaded back
//   in_en/in_data           -> input vector, in_ready back
//   out_en/out_data/out_value <- one-cycle result strobe with held result
interface xor_nn_seq_if #(
  parameter int BITS_PER_WORD = 8,
  parameter int INPUT_SIZE    = 2
);
  logic                            weights_en;
  logic signed [BITS_PER_WORD-1:0] weights_data;
  logic                            weights_ready;
  logic                            weights_loaded;
  logic                            in_en;
  logic        [INPUT_SIZE-1:0]    in_data;
  logic                            in_ready;
  logic                            out_en;
  logic                            out_data;
  logic signed [BITS_PER_WORD-1:0] out_value;

  modport master (
    output weights_en, weights_data, in_en, in_data,
    input  weights_ready, weights_loaded, in_ready, out_en, out_data, out_value
  );

  modport slave (
    input  weights_en, weights_data, in_en, in_data,
    output weights_ready, weights_loaded, in_ready, out_en, out_data, out_value
  );
endinterface

// File: rtl/xor_nn_seq.sv
// Time-multiplexed sequencer and weight store for the small XOR network.
// One shared MAC per clock evaluates the ReLU hidden layer, then the output
// neuron, and returns a one-cycle result strobe.
// Ports:
//   clk     : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : xor_nn_seq_if.slave (weight stream, input vector, result)
// Build option:
//   XOR_NN_DEFAULT_WEIGHTS_EN : when defined, reset loads the XOR weight set
//   and weights_loaded resets to 1; otherwise weights reset to 0 and a full
//   load is needed before the first inference.
//
// state   | meaning
// ST_IDLE | waiting; accepts first weight word or an input vector
// ST_LOAD | receiving weight words 1..NW-1
// ST_HID  | hidden-layer MACs, one per cycle
// ST_OUT  | output-neuron MACs, result registers on the last one
module xor_nn_seq #(
  parameter int BITS_PER_WORD = 8,
  parameter int INPUT_SIZE    = 2,
  parameter int HIDDEN_SIZE   = 2
) (
  input logic        clk,
  input logic        reset_n,
  xor_nn_seq_if.slave bus
);
  localparam int BW   = BITS_PER_WORD;
  localparam int IS   = INPUT_SIZE;
  localparam int HS   = HIDDEN_SIZE;
  localparam int N1   = (IS + 1) * HS;
  localparam int NW   = N1 + HS + 1;
  localparam int AW   = 2 * BW + 2;
  localparam int PW   = $clog2(NW);
  localparam int MAXK = (IS > HS) ? IS : HS;
  localparam int KW   = $clog2(MAXK + 1);

  localparam logic [KW-1:0] K_HID_LAST = KW'(IS);
  localparam logic [KW-1:0] K_OUT_LAST = KW'(HS);
  localparam logic [KW-1:0] J_LAST     = KW'(HS - 1);
  localparam logic [PW-1:0] P_LAST     = PW'(NW - 1);

  localparam logic signed [AW-1:0] SAT_HI = AW'((2 ** (BW - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_HID, ST_OUT} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [KW-1:0]         k_q, k_d;
  logic [KW-1:0]         j_q, j_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [IS-1:0]         in_q, in_d;
  logic                  loaded_q, loaded_d;
  logic [BW-1:0]         w_q [NW];
  logic [BW-1:0]         w_d [NW];
  logic [BW-1:0]         h_q [0:HS];
  logic [BW-1:0]         h_d [0:HS];
  logic                  out_en_q, out_en_d;
  logic                  out_data_q, out_data_d;
  logic [BW-1:0]         out_value_q, out_value_d;

  logic [IS:0]           xv;
  logic [BW-1:0]         w_cur;
  logic [BW-1:0]         h_cur;
  logic signed [2*BW-1:0] prod;
  logic signed [AW-1:0]  mac_hid;
  logic signed [AW-1:0]  mac_out;
  logic [BW-1:0]         res;

  function automatic logic [BW-1:0] relu(input logic signed [AW-1:0] a);
    if (a[AW-1])         return '0;
    else if (a > SAT_HI) return SAT_HI[BW-1:0];
    else                 return a[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] sat(input logic signed [AW-1:0] a);
    if (a > SAT_HI)      return SAT_HI[BW-1:0];
    else if (a < SAT_LO) return SAT_LO[BW-1:0];
    else                 return a[BW-1:0];
  endfunction

`ifdef XOR_NN_DEFAULT_WEIGHTS_EN
  // Flat store order: w1 column j0 {0,1,1}, column j1 {-1,1,1}, w2 {0,1,-2}.
  function automatic logic [BW-1:0] dflt_w(input int i);
    case (i)
      1, 2, 4, 5, 7: return BW'(1);
      3:             return {BW{1'b1}};
      8:             return {{(BW-1){1'b1}}, 1'b0};
      default:       return '0;
    endcase
  endfunction
`endif

  // The stream order equals MAC order, so one pointer walks w1 during ST_HID
  // and continues into w2 during ST_OUT.
  assign xv      = {in_q, 1'b1};
  assign w_cur   = w_q[ptr_q];
  assign h_cur   = (k_q == '0) ? BW'(1) : h_q[k_q];
  assign prod    = $signed(h_cur) * $signed(w_cur);
  assign mac_hid = acc_q + (xv[k_q] ? {{(AW-BW){w_cur[BW-1]}}, w_cur} : '0);
  assign mac_out = acc_q + {{(AW-2*BW){prod[2*BW-1]}}, prod};
  assign res     = sat(mac_out);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    k_d         = k_q;
    j_d         = j_q;
    acc_d       = acc_q;
    in_d        = in_q;
    loaded_d    = loaded_q;
    w_d         = w_q;
    h_d         = h_q;
    out_en_d    = 1'b0;
    out_data_d  = out_data_q;
    out_value_d = out_value_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.weights_en) begin
          w_d[0]   = bus.weights_data;
          ptr_d    = PW'(1);
          loaded_d = 1'b0;
          state_d  = ST_LOAD;
        end else if (bus.in_en && loaded_q) begin
          in_d    = bus.in_data;
          acc_d   = '0;
          ptr_d   = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = ST_HID;
        end
      end
      ST_LOAD: begin
        if (bus.weights_en) begin
          w_d[ptr_q] = bus.weights_data;
          if (ptr_q == P_LAST) begin
            loaded_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            ptr_d = ptr_q + PW'(1);
          end
        end
      end
      ST_HID: begin
        ptr_d = ptr_q + PW'(1);
        if (k_q == K_HID_LAST) begin
          h_d[j_q + KW'(1)] = relu(mac_hid);
          acc_d = '0;
          k_d   = '0;
          if (j_q == J_LAST) begin
            j_d     = '0;
            state_d = ST_OUT;
          end else begin
            j_d = j_q + KW'(1);
          end
        end else begin
          acc_d = mac_hid;
          k_d   = k_q + KW'(1);
        end
      end
      ST_OUT: begin
        ptr_d = ptr_q + PW'(1);
        if (k_q == K_OUT_LAST) begin
          out_value_d = res;
          out_data_d  = ~res[BW-1] & (|res);
          out_en_d    = 1'b1;
          acc_d       = '0;
          k_d         = '0;
          state_d     = ST_IDLE;
        end else begin
          acc_d = mac_out;
          k_d   = k_q + KW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      k_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      in_q        <= '0;
      out_en_q    <= 1'b0;
      out_data_q  <= 1'b0;
      out_value_q <= '0;
      for (int n = 0; n <= HS; n++) h_q[n] <= '0;
`ifdef XOR_NN_DEFAULT_WEIGHTS_EN
      for (int i = 0; i < NW; i++) w_q[i] <= dflt_w(i);
      loaded_q <= 1'b1;
`else
      for (int i = 0; i < NW; i++) w_q[i] <= '0;
      loaded_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      k_q         <= k_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      in_q        <= in_d;
      loaded_q    <= loaded_d;
      w_q         <= w_d;
      h_q         <= h_d;
      out_en_q    <= out_en_d;
      out_data_q  <= out_data_d;
      out_value_q <= out_value_d;
    end
  end

  assign bus.weights_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign bus.weights_loaded = loaded_q;
  assign bus.in_ready       = loaded_q & (state_q == ST_IDLE) & ~bus.weights_en;
  assign bus.out_en         = out_en_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_value      = out_value_q;
endmodule
